program_counter: RTL and testbench
==================================

# program_counter

Instruction-address register for the 16-bit CPU datapath. It holds the current 12-bit instruction address and, on each rising clock edge, either loads a new address (jumps/branches), increments by one (sequential fetch), or holds. `pc_out` drives the instruction-memory address bus and is registered (glitch-free).

## Interface
- `ADDR_W`, default 12: address width in bits; all address ports use this width.
- `RESET_VECTOR`, default 12'h000: value forced onto the PC by reset.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high; forces PC to `RESET_VECTOR` immediately.
- `pc_load`  input  1  load request; PC takes `pc_address` at the next rising edge.
- `pc_inc`  input  1  increment request; PC takes PC+1 at the next rising edge.
- `pc_address`  input  ADDR_W  jump/branch target, sampled only when `pc_load`=1.
- `pc_out`  output  ADDR_W  current PC value, registered.
- `pc_wrap`  output  1  present only with `PC_WRAP_FLAG_EN` (see Configuration).

## Operation
- Next-state priority, evaluated each rising edge:
  1. `rst`=1 → `RESET_VECTOR`. This overrides everything, asynchronously.
  2. `pc_load`=1 → `pc_address`. Load wins over increment when both are high.
  3. `pc_inc`=1 → `pc_out + 1`, modulo 2^ADDR_W.
  4. Otherwise → hold.
- Arithmetic is unsigned ADDR_W-bit. 12'hFFF + 1 wraps to 12'h000 with no carry out.
- `pc_address` is ignored when `pc_load`=0. X on `pc_address` must not propagate into the PC while `pc_load`=0.
- No handshake. Both controls are level-sensitive and are sampled once per edge. Holding `pc_inc` high advances the PC by one per cycle.
- Reset value of `pc_out` is `RESET_VECTOR`. The reset value of `pc_wrap` is 0.

## Timing
- Latency is 1 cycle: a control sampled at edge N is visible on `pc_out` just after edge N.
- Reset assertion changes `pc_out` without a clock edge.
- On reset release, the first update occurs at the first rising edge with `rst`=0.
- If reset is asserted mid-sequence, any pending load or increment is discarded. No state survives reset.
- There are no combinational paths from inputs to `pc_out`.

## Configuration
- `PC_WRAP_FLAG_EN` defined:
  - The `pc_wrap` output port exists.
  - It is a registered single-cycle pulse, high for the cycle after an increment takes the PC from all-ones to zero.
  - A load of zero, or a load while the PC is all-ones, does not pulse it.
- `PC_WRAP_FLAG_EN` undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `program_counter_pkg` holds:
  - `PC_ADDR_W` (12) and `PC_RESET_VECTOR` (12'h000) constants. These are the parameter defaults.
  - `pc_addr_t` typedef, `logic [PC_ADDR_W-1:0]`.
  - A `pc_op_e` enum {PC_HOLD, PC_INC, PC_LOAD} for the decoded operation.
- One sub-module, `pc_next_mux`, is natural:
  - Purely combinational.
  - Decodes `pc_load`/`pc_inc` into `pc_op_e` with load priority.
  - Produces the next PC value and, when enabled, the wrap indication.
- The top level contains only the async-reset state register(s).

## Test plan
- Reset: assert `rst` with `pc_out` at 12'h0A5, no clock edge → `pc_out`=12'h000 immediately. Release reset with both controls low → PC holds 12'h000.
- Hold: controls low, `pc_address`=12'h00F for 3 cycles → `pc_out` stays 12'h000, unaffected by `pc_address`.
- Load: `pc_load`=1, `pc_inc`=0, `pc_address`=12'h001 for 3 cycles → `pc_out`=12'h001 after the first edge, then stays 12'h001.
- Increment: from 12'h001, `pc_inc`=1 for 3 cycles → 12'h002, 12'h003, 12'h004 on successive edges.
- Simultaneous: `pc_load`=1, `pc_inc`=1, `pc_address`=12'h001 → `pc_out`=12'h001 and holds there (load priority, no increment).
- Wrap: load 12'hFFE, then `pc_inc`=1 for 3 cycles → 12'hFFF, 12'h000, 12'h001. With `PC_WRAP_FLAG_EN`, `pc_wrap`=1 only in the cycle `pc_out`=12'h000.

Source files
------------

// File: rtl/program_counter_pkg.sv
// program_counter_pkg
// Shared constants and types for the instruction-address register.
//   PC_ADDR_W        default address width (12)
//   PC_RESET_VECTOR  default reset address (12'h000)
//   pc_addr_t        address type at the default width
//   pc_op_e          decoded next-PC operation
package program_counter_pkg;

  localparam int unsigned PC_ADDR_W = 12;
  localparam logic [PC_ADDR_W-1:0] PC_RESET_VECTOR = 12'h000;

  typedef logic [PC_ADDR_W-1:0] pc_addr_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } pc_op_e;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux
// Purely combinational next-PC selection with load-over-increment priority.
// Optional feature macro: PC_WRAP_FLAG_EN (adds wrap_o).
// Ports:
//   pc_i       current PC
//   load_i     load request
//   inc_i      increment request
//   addr_i     load target (only routed when load_i=1)
//   pc_next_o  next PC value
//   wrap_o     increment is taking the PC from all-ones to zero (PC_WRAP_FLAG_EN only)
module pc_next_mux
  import program_counter_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] pc_next_o
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic              wrap_o
`endif
);

  pc_op_e op;

  always_comb begin
    op = PC_HOLD;
    if (load_i) begin
      op = PC_LOAD;
    end else if (inc_i) begin
      op = PC_INC;
    end
  end

  // addr_i is only selected on the load arm, so an undriven target cannot
  // leak into the PC while no load is requested.
  always_comb begin
    pc_next_o = pc_i;
    unique case (op)
      PC_LOAD: pc_next_o = addr_i;
      PC_INC:  pc_next_o = pc_i + ADDR_W'(1);
      default: pc_next_o = pc_i;
    endcase
  end

`ifdef PC_WRAP_FLAG_EN
  always_comb begin
    wrap_o = (op == PC_INC) && (pc_i == '1);
  end
`endif

endmodule

// File: rtl/program_counter.sv
// program_counter
// Instruction-address register: loads, increments (mod 2^ADDR_W) or holds
// on each rising edge; asynchronous active-high reset to RESET_VECTOR.
// Optional feature macro: PC_WRAP_FLAG_EN (adds the pc_wrap pulse output).
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   pc_load     load request (wins over pc_inc)
//   pc_inc      increment request
//   pc_address  load target
//   pc_out      registered current PC
//   pc_wrap     registered one-cycle pulse after an all-ones -> zero increment
//               (PC_WRAP_FLAG_EN only)
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned          ADDR_W       = PC_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic [ADDR_W-1:0] pc_address,
  output logic [ADDR_W-1:0] pc_out
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic              pc_wrap
`endif
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

`ifdef PC_WRAP_FLAG_EN
  logic wrap_q;
  logic wrap_d;
`endif

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_next (
    .pc_i      (pc_q),
    .load_i    (pc_load),
    .inc_i     (pc_inc),
    .addr_i    (pc_address),
    .pc_next_o (pc_d)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrap_o    (wrap_d)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

`ifdef PC_WRAP_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign pc_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter
// Scoreboarded bench for program_counter: directed scenarios followed by
// randomized controls, checked against an arithmetic reference model.
module tb_program_counter;

  localparam int unsigned AW  = 12;
  localparam int unsigned MOD = 4096;

  typedef struct {
    int unsigned pc;
    bit          wrap;
    string       tag;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          pc_load;
  logic          pc_inc;
  logic [AW-1:0] pc_address;
  logic [AW-1:0] pc_out;
`ifdef PC_WRAP_FLAG_EN
  logic          pc_wrap;
`endif

  exp_t        exp_q[$];
  int unsigned model_pc;
  int          n_vec;
  int          n_bad;

  program_counter #(
    .ADDR_W       (AW),
    .RESET_VECTOR (12'h000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .pc_address (pc_address),
    .pc_out     (pc_out)
`ifdef PC_WRAP_FLAG_EN
    ,
    .pc_wrap    (pc_wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per post-reset edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (int'(pc_out) != e.pc) begin
        n_bad++;
        $display("FAIL %s pc_out: got %03h expected %03h", e.tag, pc_out, e.pc[AW-1:0]);
      end
`ifdef PC_WRAP_FLAG_EN
      n_vec++;
      if (pc_wrap != e.wrap) begin
        n_bad++;
        $display("FAIL %s pc_wrap: got %0b expected %0b", e.tag, pc_wrap, e.wrap);
      end
`endif
    end
  end

  // Issue one cycle of controls from a negedge, record the model's answer,
  // and return at the next negedge.
  task automatic step(input bit ld, input bit in, input logic [AW-1:0] addr,
                      input string tag);
    exp_t e;
    pc_load    = ld;
    pc_inc     = in;
    pc_address = addr;
    e.wrap = 1'b0;
    if (ld) begin
      model_pc = int'(addr);
    end else if (in) begin
      e.wrap   = (model_pc == MOD - 1);
      model_pc = (model_pc + 1) % MOD;
    end
    e.pc  = model_pc;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_now(input string tag, input int unsigned want);
    n_vec++;
    if (int'(pc_out) != want) begin
      n_bad++;
      $display("FAIL %s pc_out: got %03h expected %03h", tag, pc_out, want[AW-1:0]);
    end
`ifdef PC_WRAP_FLAG_EN
    n_vec++;
    if (pc_wrap != 1'b0) begin
      n_bad++;
      $display("FAIL %s pc_wrap: got %0b expected 0", tag, pc_wrap);
    end
`endif
  endtask

  // Assert reset between edges with controls still requesting work; the
  // PC must clear immediately and stay cleared across a clock edge.
  task automatic async_reset(input string tag);
    #2;
    pc_load    = 1'b1;
    pc_inc     = 1'b1;
    pc_address = 12'h5A5;
    rst        = 1'b1;
    #1;
    check_now({tag, "_assert"}, 0);
    @(posedge clk);
    @(negedge clk);
    check_now({tag, "_held"}, 0);
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    rst      = 1'b0;
    model_pc = 0;
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    model_pc   = 0;
    rst        = 1'b1;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_address = '0;
    @(negedge clk);
    @(negedge clk);
    check_now("por", 0);
    rst = 1'b0;

    step(1'b1, 1'b0, 12'h0A5, "pre_reset_load");
    async_reset("reset");
    step(1'b0, 1'b0, 12'h000, "reset_release_hold");

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h00F, "hold");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'h001, "load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'h7C3, "inc");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'h001, "simul");
    step(1'b0, 1'b0, 'x, "x_addr_hold");

    step(1'b1, 1'b0, 12'hFFE, "wrap_load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'h000, "wrap_inc");
    step(1'b1, 1'b0, 12'hFFF, "load_ones");
    step(1'b1, 1'b0, 12'h000, "load_zero_from_ones");
    step(1'b1, 1'b0, 12'hFFF, "load_ones2");
    step(1'b1, 1'b1, 12'h000, "load_beats_inc_at_ones");

    for (int i = 0; i < 1500; i++) begin
      logic [AW-1:0] a;
      bit ld, in;
      ld = ($urandom_range(0, 3) == 0);
      in = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       a = 12'hFFE;
        1:       a = 12'hFFF;
        default: a = AW'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_reset");
      end else begin
        step(ld, in, a, "random");
      end
    end

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
